ram_wr_arbiter: RTL

- Owns the single write port (port A) of the team's dual-port async-read RAM and shares it between two write clients with round-robin arbitration.
- After reset it sequences an initialisation sweep that writes INIT_VALUE to every RAM location, then opens the port to the clients.
- Port B is a read passthrough so both clients see one coherent memory.
- Sits between two producer blocks and one RAM instance.

---
 rtl/ram_wr_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ram_wr_arbiter.sv
// rtl/ram_wr_arbiter.sv - round-robin arbiter for the RAM write port with a power-up init sweep
module ram_wr_arbiter #(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic                  ack0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] din1,
    output logic                  ack1,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  init_done,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    input  logic [DATA_WIDTH-1:0] ram_dout_b
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   init_cnt, init_cnt_nxt;
    logic                    last_grant, last_grant_nxt;
    logic                    ack0_nxt, ack1_nxt;
    logic                    init_done_nxt;
    logic                    ram_we_nxt;
    logic [ADDR_WIDTH-1:0]   ram_addr_a_nxt;
    logic [DATA_WIDTH-1:0]   ram_din_a_nxt;

    // A client whose ack is currently high is in its retire cycle and must
    // not be accepted again for the same held request.
    logic elig0, elig1, pick1;
    assign elig0 = req0 & ~ack0;
    assign elig1 = req1 & ~ack1;
    // Client 1 wins when it is alone, or on a tie when client 0 was served last.
    assign pick1 = elig1 & (~elig0 | ~last_grant);

    assign ram_addr_b = rd_addr;
    assign rd_data    = ram_dout_b;

    // Next-state and next-output decode for the sweep and arbitration phases.
    always_comb begin
        state_nxt      = state;
        init_cnt_nxt   = init_cnt;
        last_grant_nxt = last_grant;
        ack0_nxt       = 1'b0;
        ack1_nxt       = 1'b0;
        init_done_nxt  = init_done;
        ram_we_nxt     = 1'b0;
        ram_addr_a_nxt = ram_addr_a;
        ram_din_a_nxt  = ram_din_a;
        case (state)
            ST_INIT: begin
                ram_we_nxt     = 1'b1;
                ram_addr_a_nxt = init_cnt;
                ram_din_a_nxt  = INIT_VALUE;
                init_cnt_nxt   = init_cnt + 1'b1;
                // init_done rises together with the last sweep address.
                if (init_cnt == LAST_ADDR) begin
                    state_nxt     = ST_RUN;
                    init_done_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (elig0 || elig1) begin
                    ram_we_nxt = 1'b1;
                    if (pick1) begin
                        ram_addr_a_nxt = addr1;
                        ram_din_a_nxt  = din1;
                        ack1_nxt       = 1'b1;
                        last_grant_nxt = 1'b1;
                    end else begin
                        ram_addr_a_nxt = addr0;
                        ram_din_a_nxt  = din0;
                        ack0_nxt       = 1'b1;
                        last_grant_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // State and registered outputs; reset restarts the sweep from address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_INIT;
            init_cnt   <= '0;
            last_grant <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            init_done  <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr_a <= '0;
            ram_din_a  <= '0;
        end else begin
            state      <= state_nxt;
            init_cnt   <= init_cnt_nxt;
            last_grant <= last_grant_nxt;
            ack0       <= ack0_nxt;
            ack1       <= ack1_nxt;
            init_done  <= init_done_nxt;
            ram_we     <= ram_we_nxt;
            ram_addr_a <= ram_addr_a_nxt;
            ram_din_a  <= ram_din_a_nxt;
        end
    end

endmodule
